// File: rtl/ifetch.sv
// Instruction fetch unit: PC register driving instruction memory, feeding a small FIFO of {pc, word}.
// Optional backpressure counter on stall_cnt enabled by defining IFETCH_STALL_CNT_EN.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  input  logic        ins_ready,
  output logic [31:0] stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [31:0]      pc_reg, pc_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      buf_pc_reg   [DEPTH];
  logic [31:0]      buf_data_reg [DEPTH];
  logic             push, pop;

  assign imem_addr = pc_reg;
  assign ins_valid = (count_reg != '0);
  assign ins_out   = buf_data_reg[head_reg];
  assign ins_pc    = buf_pc_reg[head_reg];

  // A pop frees a slot in the same cycle, so a full buffer can still accept a push.
  assign pop  = ins_valid && ins_ready;
  assign push = !redirect_valid && ((count_reg != DEPTH_C) || pop);

  always_comb begin
    pc_next    = pc_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (redirect_valid) begin
      pc_next    = redirect_pc & 32'hFFFF_FFFC;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        pc_next   = pc_reg + 32'd4;
        tail_next = (tail_reg == LAST_PTR) ? '0 : tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_next = (head_reg == LAST_PTR) ? '0 : head_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entries are cleared on reset so the head reads zero while empty after reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_pc_reg[gi]   <= '0;
          buf_data_reg[gi] <= '0;
        end else if (push && (tail_reg == PTR_W'(gi))) begin
          buf_pc_reg[gi]   <= pc_reg;
          buf_data_reg[gi] <= imem_data;
        end
      end
    end
  endgenerate

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (ins_valid && !ins_ready) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed testbench for ifetch: reset, full-buffer stall, redirect, PC wrap and mid-stream reset.
module tb_ifetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

`ifdef IFETCH_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_out        (ins_out),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program at 0..12; every other address returns the inverted address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0090_0113;
      32'h0000_0008: mem_word = 32'h0020_80B3;
      32'h0000_000C: mem_word = 32'h0020_A4A3;
      default:       mem_word = ~a;
    endcase
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %-16s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    #2;
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_out",   ins_out,   32'h0);
    check("rst_pc",    ins_pc,    32'h0);
    check("rst_stall", stall_cnt, 32'h0);

    // Backpressure for 5 cycles fills DEPTH=2 buffer
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("bp1_valid", {31'd0, ins_valid}, 32'd1);
    check("bp1_pc",    ins_pc,    32'h0);
    check("bp1_addr",  imem_addr, 32'h4);
    @(negedge clk);
    @(negedge clk);
    check("bp3_out",   ins_out,   32'h0050_0093);
    @(negedge clk);
    @(negedge clk);
    check("bp5_addr",  imem_addr, 32'h8);
    check("bp5_out",   ins_out,   32'h0050_0093);
    check("bp5_pc",    ins_pc,    32'h0);
    check("bp5_stall", stall_cnt, CNT_EN ? 32'd4 : 32'd0);

    // Redirect while full to an unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_000E;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd_valid",  {31'd0, ins_valid}, 32'd0);
    check("rd_addr",   imem_addr, 32'hC);
    check("rd_stall",  stall_cnt, CNT_EN ? 32'd5 : 32'd0);
    @(negedge clk);
    check("rd_out",    ins_out,   32'h0020_A4A3);
    check("rd_pc",     ins_pc,    32'hC);
    check("rd_addr2",  imem_addr, 32'h10);

    // Drain one with ready, then redirect to top of address space
    ins_ready = 1'b1;
    @(negedge clk);
    check("dr_pc",     ins_pc,    32'h10);
    check("dr_out",    ins_out,   32'hFFFF_FFEF);
    check("dr_stall",  stall_cnt, CNT_EN ? 32'd5 : 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("wr_valid",  {31'd0, ins_valid}, 32'd0);
    check("wr_addr",   imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wr_pc1",    ins_pc,    32'hFFFF_FFFC);
    check("wr_out1",   ins_out,   32'h0000_0003);
    check("wr_addr1",  imem_addr, 32'h0);
    @(negedge clk);
    check("wr_pc2",    ins_pc,    32'h0);
    check("wr_out2",   ins_out,   32'h0050_0093);

    // Fresh reset, streaming with ready=1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s0_out", ins_out, 32'h0050_0093);
    check("s0_pc",  ins_pc,  32'h0);
    @(negedge clk);
    check("s1_out", ins_out, 32'h0090_0113);
    check("s1_pc",  ins_pc,  32'h4);
    @(negedge clk);
    check("s2_out", ins_out, 32'h0020_80B3);
    check("s2_pc",  ins_pc,  32'h8);
    @(negedge clk);
    check("s3_out", ins_out, 32'h0020_A4A3);
    check("s3_pc",  ins_pc,  32'hC);
    check("s3_stall", stall_cnt, 32'd0);

    // Stop popping so two entries are buffered, then reset asynchronously
    ins_ready = 1'b0;
    @(negedge clk);
    check("hold_pc",   ins_pc,    32'hC);
    check("hold_addr", imem_addr, 32'h14);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, ins_valid}, 32'd0);
    check("ar_addr",  imem_addr, 32'h0);
    check("ar_pc",    ins_pc,    32'h0);
    check("ar_stall", stall_cnt, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    ins_ready = 1'b1;
    @(negedge clk);
    check("rs0_out", ins_out, 32'h0050_0093);
    check("rs0_pc",  ins_pc,  32'h0);
    @(negedge clk);
    check("rs1_out", ins_out, 32'h0090_0113);
    check("rs1_pc",  ins_pc,  32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction buffer entry count (legal 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory, byte-addressed, little-endian word returned.
REQ-006 SHALL have port imem_data  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target address.
REQ-009 SHALL have port ins_valid  output  1  buffer head holds a valid instruction.
REQ-010 SHALL have port ins_out  output  32  instruction word at buffer head.
REQ-011 SHALL have port ins_pc  output  32  address of ins_out.
REQ-012 SHALL have port ins_ready  input  1  decode accepts head this cycle.
REQ-013 SHALL have port stall_cnt  output  32  backpressure cycle count (see Configuration).

Function
REQ-014 SHALL drive imem_addr = pc register continuously; no other address source.
REQ-015 Push: SHALL write {pc, imem_data} into buffer and set pc <= pc + 4 when redirect_valid=0 and (count < DEPTH or pop this cycle).
REQ-016 Pop: SHALL occur when ins_valid && ins_ready; head advances by one entry.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; push on full allowed only with same-cycle pop.
REQ-018 Full without pop: SHALL hold pc and buffer; imem_addr stable.
REQ-019 ins_valid SHALL equal (count != 0); ins_out/ins_pc SHALL come from registered head entry, never combinationally from imem_data.
REQ-020 Latency: word at address A SHALL appear on ins_out one cycle after imem_addr=A with push.
REQ-021 Redirect: SHALL flush all entries (count <= 0), set pc <= {redirect_pc[31:2], 2'b00}, suppress push that cycle; a pop in the same cycle has no further effect.
REQ-022 Redirect SHALL have priority over push, pop and full-stall.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Buffer pointers SHALL wrap modulo DEPTH; ordering strictly FIFO.
REQ-025 ins_out and ins_pc SHALL hold stable while ins_valid=1 and ins_ready=0.

Reset
REQ-026 On rst_n=0, asynchronously: pc=RESET_PC, count=0, pointers=0, ins_valid=0, ins_out=0, ins_pc=0, stall_cnt=0.
REQ-027 Reset mid-operation SHALL discard buffered instructions; first push after release occurs on first rising edge with rst_n=1.

Configuration
REQ-028 With IFETCH_STALL_CNT_EN defined: stall_cnt SHALL increment by 1 each cycle ins_valid=1 and ins_ready=0, wrap at 2^32, clear only on reset.
REQ-029 Without IFETCH_STALL_CNT_EN: stall_cnt SHALL be constant 0 and no counter register synthesized.

Verification
REQ-030 Memory holds 0x00500093@0, 0x00900113@4, 0x002080B3@8, 0x0020A4A3@12, ins_ready=1 after reset -> ins_out sequence 0x00500093, 0x00900113, 0x002080B3, 0x0020A4A3 on consecutive cycles with ins_pc 0,4,8,12.
REQ-031 ins_ready=0 for 5 cycles after reset, DEPTH=2 -> buffer holds entries pc 0 and 4, imem_addr stuck at 8, ins_out=0x00500093 stable; stall_cnt=4 with macro (ins_valid high from cycle 2), 0 without.
REQ-032 Full buffer, redirect_valid=1 redirect_pc=0x0000000E -> next cycle ins_valid=0, imem_addr=0x0000000C; following cycle ins_out=0x0020A4A3, ins_pc=0x0000000C.
REQ-033 Redirect to 0xFFFFFFFC with ins_ready=1 -> ins_pc 0xFFFFFFFC then 0x00000000.
REQ-034 Assert rst_n=0 mid-stream with 2 entries buffered -> ins_valid=0 immediately (before next edge), imem_addr=RESET_PC; restart fetch from RESET_PC.
